q_measure: RTL and testbench

Q_MEASURE -- requirements
Module: q_measure

---
 rtl/q_measure.sv | 203 ++++++++++++++++++++
 tb/tb_q_measure.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_measure.sv
// Resonator Q measurement: excites the resonator, then counts ring-down zero-cross edges
// until the envelope drops or the oscillation stalls. Optional build macro: Q_MEAS_AVG_EN.
module q_measure #(
    parameter int BUS_WIDTH     = 10,
    parameter int EXCITE_CYCLES = 16,
    parameter int GAP_CYCLES    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 osc_in,
    input  logic                 env_above,
    output logic                 excite,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy,
    output logic                 timeout,
    output logic [2:0]           o_dbg_state
);

    localparam int EW = $clog2(EXCITE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [EW-1:0]        EXC_LAST = EW'(EXCITE_CYCLES - 1);
    localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [BUS_WIDTH-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXCITE = 3'd1,
        S_ARM    = 3'd2,
        S_COUNT  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_osc_s1, r_osc_s2, r_osc_s3;
    logic                 r_env_s1, r_env_s2;
    logic [EW-1:0]        r_exc_cnt;
    logic [GW-1:0]        r_gap;
    logic [BUS_WIDTH-1:0] r_cnt;
    logic                 r_meas_to;
    logic                 r_excite;
    logic [BUS_WIDTH-1:0] r_q;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_timeout;

    logic                 w_osc_rise;
    logic [BUS_WIDTH-1:0] w_cnt_next;

`ifdef Q_MEAS_AVG_EN
    logic [1:0]           r_avg_idx;
    logic [BUS_WIDTH+1:0] r_sum;
    logic                 r_to_acc;
    logic [BUS_WIDTH+1:0] w_sum;
    logic                 w_to_any;

    assign w_sum    = r_sum + {2'b00, r_cnt};
    assign w_to_any = r_to_acc | r_meas_to;
`endif

    // s3 only holds the previous synchronized osc level for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_osc_s1 <= 1'b0;
            r_osc_s2 <= 1'b0;
            r_osc_s3 <= 1'b0;
            r_env_s1 <= 1'b0;
            r_env_s2 <= 1'b0;
        end else begin
            r_osc_s1 <= osc_in;
            r_osc_s2 <= r_osc_s1;
            r_osc_s3 <= r_osc_s2;
            r_env_s1 <= env_above;
            r_env_s2 <= r_env_s1;
        end
    end

    assign w_osc_rise = r_osc_s2 & ~r_osc_s3;
    assign w_cnt_next = (w_osc_rise && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_exc_cnt <= '0;
            r_gap     <= '0;
            r_cnt     <= '0;
            r_meas_to <= 1'b0;
            r_excite  <= 1'b0;
            r_q       <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
`ifdef Q_MEAS_AVG_EN
            r_avg_idx <= '0;
            r_sum     <= '0;
            r_to_acc  <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
            if (!enable && r_state != S_IDLE) begin
                // Abort: results and the result flags stay as they were.
                r_state  <= S_IDLE;
                r_excite <= 1'b0;
                r_busy   <= 1'b0;
`ifdef Q_MEAS_AVG_EN
                r_avg_idx <= '0;
                r_sum     <= '0;
                r_to_acc  <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && enable) begin
                            r_state   <= S_EXCITE;
                            r_excite  <= 1'b1;
                            r_busy    <= 1'b1;
                            r_exc_cnt <= '0;
                        end
                    end
                    S_EXCITE: begin
                        if (r_exc_cnt == EXC_LAST) begin
                            r_state   <= S_ARM;
                            r_excite  <= 1'b0;
                            r_gap     <= '0;
                            r_meas_to <= 1'b0;
                        end else begin
                            r_exc_cnt <= r_exc_cnt + 1'b1;
                        end
                    end
                    S_ARM: begin
                        if (r_env_s2) begin
                            r_state <= S_COUNT;
                            r_cnt   <= '0;
                            r_gap   <= '0;
                        end else if (r_gap == GAP_LAST) begin
                            r_state   <= S_DONE;
                            r_cnt     <= '0;
                            r_meas_to <= 1'b1;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    S_COUNT: begin
                        r_cnt <= w_cnt_next;
                        if (!r_env_s2) begin
                            r_state <= S_DONE;
                        end else if (w_osc_rise) begin
                            r_gap <= '0;
                        end else if (r_gap == GAP_LAST) begin
                            r_state   <= S_DONE;
                            r_meas_to <= 1'b1;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    S_DONE: begin
`ifdef Q_MEAS_AVG_EN
                        if (r_avg_idx == 2'd3) begin
                            r_q       <= w_sum[BUS_WIDTH+1:2];
                            r_timeout <= w_to_any;
                            r_ready   <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_avg_idx <= '0;
                            r_sum     <= '0;
                            r_to_acc  <= 1'b0;
                        end else begin
                            // Chain straight into the next excitation of the set of four.
                            r_avg_idx <= r_avg_idx + 1'b1;
                            r_sum     <= w_sum;
                            r_to_acc  <= w_to_any;
                            r_state   <= S_EXCITE;
                            r_excite  <= 1'b1;
                            r_exc_cnt <= '0;
                        end
`else
                        r_q       <= r_cnt;
                        r_timeout <= r_meas_to;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
`endif
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_excite <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign excite      = r_excite;
    assign q_measured  = r_q;
    assign ready       = r_ready;
    assign busy        = r_busy;
    assign timeout     = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_q_measure.sv
// Directed + randomized bench for q_measure; expected results come from a ring-down model
// (count = min(edges, 2**W-1), timeout when oscillation stalls) held in an expected queue.
module tb_q_measure;
  localparam int BW   = 10;
  localparam int EXC  = 16;
  localparam int GAP  = 255;
  localparam int QMAX = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic          osc_in = 1'b0;
  logic          env_above = 1'b0;
  logic          excite;
  logic [BW-1:0] q_measured;
  logic          ready;
  logic          busy;
  logic          timeout;
  logic [2:0]    o_dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_total = 0;
  int last_q = 0;
  logic [BW-1:0] exp_q[$];
  logic          exp_to[$];

  q_measure #(.BUS_WIDTH(BW), .EXCITE_CYCLES(EXC), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .osc_in(osc_in),
    .env_above(env_above), .excite(excite), .q_measured(q_measured), .ready(ready),
    .busy(busy), .timeout(timeout), .o_dbg_state(o_dbg_state)
  );

  // clock / ready monitor
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (ready === 1'b1) ready_total++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic osc_edges(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      osc_in = 1'b1;
      tick(half);
      osc_in = 1'b0;
      tick(half);
    end
  endtask

  task automatic wait_excite(input string tag);
    int w = 0;
    int g = 0;
    while (excite !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    while (excite === 1'b1 && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_excite_len"}, w, EXC);
  endtask

  task automatic wait_ready(input int budget, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < budget) begin
      if (ready === 1'b1) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  // One full measurement; the model result is queued before stimulus starts.
  task automatic run_meas(input string tag, input int n, input int half, input bit stall);
    int cyc;
    bit got;
    int ev;
    logic [BW-1:0] eq;
    logic et;
    ev = (n > QMAX) ? QMAX : n;
    exp_q.push_back(ev[BW-1:0]);
    exp_to.push_back(stall);
    env_above = 1'b0;
    osc_in = 1'b0;
    pulse_start();
    chk({tag, "_busy"}, busy, 1);
    wait_excite(tag);
    env_above = 1'b1;
    tick(4);
    osc_edges(n, half);
    if (!stall) env_above = 1'b0;
    wait_ready(GAP + 40, cyc, got);
    eq = exp_q.pop_front();
    et = exp_to.pop_front();
    chk({tag, "_ready_seen"}, got, 1);
    if (got) begin
      chk({tag, "_q"}, q_measured, eq);
      chk({tag, "_timeout"}, timeout, et);
      if (stall) chk({tag, "_gap_time"}, (cyc >= GAP - 8 && cyc <= GAP + 8), 1);
      @(negedge clk);
      chk({tag, "_ready_1cyc"}, ready, 0);
      chk({tag, "_busy_done"}, busy, 0);
      last_q = eq;
    end
    env_above = 1'b0;
    tick(3);
  endtask

  initial begin
    int cyc;
    int rc;
    bit got;
    int n;
    int h;

    // reset state
    tick(3);
    chk("rst_q", q_measured, 0);
    chk("rst_busy", busy, 0);
    chk("rst_excite", excite, 0);
    chk("rst_ready", ready, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b1;
    tick(3);

`ifdef Q_MEAS_AVG_EN
    begin
      int runs[4];
      runs = '{100, 101, 102, 104};
      rc = ready_total;
      pulse_start();
      for (int k = 0; k < 4; k++) begin
        wait_excite("avg");
        env_above = 1'b1;
        tick(4);
        osc_edges(runs[k], 1);
        env_above = 1'b0;
        tick(4);
      end
      wait_ready(GAP + 40, cyc, got);
      chk("avg_ready_seen", got, 1);
      chk("avg_q", q_measured, (runs[0] + runs[1] + runs[2] + runs[3]) / 4);
      chk("avg_timeout", timeout, 0);
      tick(3);
      chk("avg_one_ready", ready_total - rc, 1);
    end
`else
    run_meas("basic", 100, 2, 1'b0);
    run_meas("gap", 20, 1, 1'b1);

    // mid-count asynchronous reset
    env_above = 1'b0;
    pulse_start();
    wait_excite("rst_mid");
    env_above = 1'b1;
    tick(4);
    osc_edges(30, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_q", q_measured, 0);
    chk("rst_mid_timeout", timeout, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_excite", excite, 0);
    chk("rst_mid_ready", ready, 0);
    env_above = 1'b0;
    @(negedge clk) start = 1'b1;
    tick(3);
    start = 1'b0;
    rst = 1'b1;
    tick(5);
    chk("rst_start_ignored", busy, 0);
    chk("rst_state_idle", o_dbg_state, 0);
    run_meas("post_rst", 63, 2, 1'b0);

    // envelope never rises -> empty timed-out result
    rc = ready_total;
    pulse_start();
    wait_excite("arm_to");
    wait_ready(GAP + 40, cyc, got);
    chk("arm_to_ready_seen", got, 1);
    chk("arm_to_q", q_measured, 0);
    chk("arm_to_timeout", timeout, 1);
    tick(2);
    last_q = 0;

    run_meas("sat", 1500, 1, 1'b0);

    // abort mid-count
    rc = ready_total;
    pulse_start();
    wait_excite("abort");
    env_above = 1'b1;
    tick(4);
    osc_edges(50, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_excite", excite, 0);
    enable = 1'b1;
    env_above = 1'b0;
    tick(GAP + 20);
    chk("abort_no_ready", ready_total - rc, 0);
    chk("abort_q_hold", q_measured, last_q);

    // abort during excitation
    pulse_start();
    tick(4);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_exc_excite", excite, 0);
    chk("abort_exc_busy", busy, 0);
    enable = 1'b1;
    tick(3);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 400);
      h = $urandom_range(1, 3);
      run_meas("rand", n, h, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
